// File: rtl/scc_bus_interface_pkg.sv
// Shared types and constants for the SCC slot bus front end.
package scc_bus_interface_pkg;

  localparam int unsigned A_W      = 15;
  localparam int unsigned D_W      = 8;
  localparam int unsigned RD_CNT_W = 3;
  localparam int unsigned WARM_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ACT = 2'd1,
    RD_ACT = 2'd2
  } bus_state_e;

  // Address/data captured on a request edge
  typedef struct packed {
    logic [A_W-1:0] a;
    logic [D_W-1:0] d;
  } bus_req_t;

  // Saturating increment for the read-cycle counter
  function automatic logic [RD_CNT_W-1:0] cnt_sat_inc(input logic [RD_CNT_W-1:0] c);
    return (&c) ? c : c + RD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/scc_bus_interface_sync.sv
// Single-bit multi-flop synchronizer; presets to 1 so strobes read inactive.
module scc_bus_interface_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the async input down the chain
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  // Chain register, preset to inactive (high)
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) sync_q <= '1;
    else         sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/scc_bus_interface.sv
// MSX slot strobe front end for scc_core: synchronizes /SLTSL,/RD,/WR,
// issues one-cycle requests and drives read data back with a registered OE.
module scc_bus_interface
  import scc_bus_interface_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           slot_nsltsl,
  input  logic           slot_nrd,
  input  logic           slot_nwr,
  input  logic [A_W-1:0] slot_a,
  input  logic [D_W-1:0] slot_d_in,
  output logic [D_W-1:0] slot_d_out,
  output logic           slot_d_oe,
  input  logic [D_W-1:0] q,
  input  logic           ext_mem_ncs,
  output logic           wrreq,
  output logic           rdreq,
  output logic           wr_active,
  output logic           rd_active,
  output logic [A_W-1:0] a,
  output logic [D_W-1:0] d
);

  logic s_sel, s_rd, s_wr;

  scc_bus_interface_sync #(.STAGES(SYNC_STAGES)) u_sync_sel (
    .clk(clk), .nreset(nreset), .din(slot_nsltsl), .dout(s_sel));
  scc_bus_interface_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .nreset(nreset), .din(slot_nrd), .dout(s_rd));
  scc_bus_interface_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .nreset(nreset), .din(slot_nwr), .dout(s_wr));

  bus_state_e          state_q, state_d;
  logic [RD_CNT_W-1:0] cnt_q, cnt_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                prev_rd_q, prev_rd_d;
  logic                prev_wr_q, prev_wr_d;
  bus_req_t            req_q, req_d;
  logic                wrreq_q, wrreq_d;
  logic                rdreq_q, rdreq_d;
  logic                wr_active_q, wr_active_d;
  logic                rd_active_q, rd_active_d;
  logic [D_W-1:0]      dout_q, dout_d;
  logic                oe_q, oe_d;
  logic                edge_en, wr_fall, rd_fall;

  // Edge detection stays off until the preset synchronizer contents have
  // flushed, so a strobe held low across reset release is not a falling edge.
  always_comb begin
    edge_en = (warm_q == WARM_W'(SYNC_STAGES + 1));
    wr_fall = edge_en && prev_wr_q && !s_wr;
    rd_fall = edge_en && prev_rd_q && !s_rd;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    warm_d    = edge_en ? warm_q : warm_q + WARM_W'(1);
    prev_rd_d = s_rd;
    prev_wr_d = s_wr;
    req_d     = req_q;
    wrreq_d   = 1'b0;
    rdreq_d   = 1'b0;
    dout_d    = dout_q;

    case (state_q)
      IDLE: begin
        if (!s_sel && wr_fall && s_rd) begin
          state_d   = WR_ACT;
          wrreq_d   = 1'b1;
          req_d.a   = slot_a;
          req_d.d   = slot_d_in;
        end else if (!s_sel && rd_fall && s_wr) begin
          state_d   = RD_ACT;
          rdreq_d   = 1'b1;
          req_d.a   = slot_a;
        end
      end
      WR_ACT: begin
        if (s_wr || s_sel) state_d = IDLE;
      end
      RD_ACT: begin
        dout_d = q;
        if (s_rd || s_sel) state_d = IDLE;
        else               cnt_d   = cnt_sat_inc(cnt_q);
      end
      default: state_d = IDLE;
    endcase

    wr_active_d = (state_d == WR_ACT);
    rd_active_d = (state_d == RD_ACT);
    oe_d        = (state_d == RD_ACT) && (cnt_d >= RD_CNT_W'(RD_LATENCY)) && ext_mem_ncs;
  end

  // State and output registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      warm_q      <= '0;
      prev_rd_q   <= 1'b1;
      prev_wr_q   <= 1'b1;
      req_q       <= '0;
      wrreq_q     <= 1'b0;
      rdreq_q     <= 1'b0;
      wr_active_q <= 1'b0;
      rd_active_q <= 1'b0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      warm_q      <= warm_d;
      prev_rd_q   <= prev_rd_d;
      prev_wr_q   <= prev_wr_d;
      req_q       <= req_d;
      wrreq_q     <= wrreq_d;
      rdreq_q     <= rdreq_d;
      wr_active_q <= wr_active_d;
      rd_active_q <= rd_active_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
    end
  end

  assign wrreq      = wrreq_q;
  assign rdreq      = rdreq_q;
  assign wr_active  = wr_active_q;
  assign rd_active  = rd_active_q;
  assign a          = req_q.a;
  assign d          = req_q.d;
  assign slot_d_out = dout_q;
  assign slot_d_oe  = oe_q;

endmodule

// File: tb/tb_scc_bus_interface.sv
// Scoreboard bench for scc_bus_interface: stimulus pushes expected request
// and OE events; a negedge monitor pops and compares them.
module tb_scc_bus_interface;

  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_OE = 2;

  typedef struct {
    int          kind;
    logic [14:0] a;
    logic [7:0]  d;
  } exp_t;

  logic        clk;
  logic        nreset;
  logic        slot_nsltsl, slot_nrd, slot_nwr;
  logic [14:0] slot_a;
  logic [7:0]  slot_d_in, slot_d_out, q, d;
  logic        slot_d_oe, ext_mem_ncs;
  logic        wrreq, rdreq, wr_active, rd_active;
  logic [14:0] a;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic oe_prev = 1'b0;

  scc_bus_interface dut (
    .clk(clk), .nreset(nreset),
    .slot_nsltsl(slot_nsltsl), .slot_nrd(slot_nrd), .slot_nwr(slot_nwr),
    .slot_a(slot_a), .slot_d_in(slot_d_in),
    .slot_d_out(slot_d_out), .slot_d_oe(slot_d_oe),
    .q(q), .ext_mem_ncs(ext_mem_ncs),
    .wrreq(wrreq), .rdreq(rdreq), .wr_active(wr_active), .rd_active(rd_active),
    .a(a), .d(d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [14:0] ea, input logic [7:0] ed);
    exp_t e;
    e.kind = kind; e.a = ea; e.d = ed;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every request pulse and every OE rising edge
  task automatic handle(input int kind, input logic [14:0] act_a, input logic [7:0] act_d);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d a=%0h d=%0h with nothing expected", kind, act_a, act_d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != K_OE && e.a !== act_a) || e.d !== act_d) begin
        errors++;
        $display("FAIL event: got kind %0d a=%0h d=%0h expected kind %0d a=%0h d=%0h",
                 kind, act_a, act_d, e.kind, e.a, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (wrreq) handle(K_WR, a, d);
    if (rdreq) handle(K_RD, a, d);
    if (slot_d_oe && !oe_prev) handle(K_OE, 15'h0, slot_d_out);
    oe_prev = slot_d_oe;
  end

  initial begin
    int cnt;
    nreset = 1'b0; slot_nsltsl = 1'b1; slot_nrd = 1'b1; slot_nwr = 1'b1;
    slot_a = '0; slot_d_in = '0; q = '0; ext_mem_ncs = 1'b1;
    #12;
    chk("reset_outputs", {wrreq, rdreq, wr_active, rd_active, slot_d_oe}, 5'b0);
    chk("reset_a_d", {a, d, slot_d_out}, 31'h0);
    repeat (3) tick();
    @(negedge clk) nreset = 1'b1;
    repeat (8) tick();
    slot_nsltsl = 1'b0;
    repeat (4) tick();

    // Write cycle
    slot_a = 15'h1800; slot_d_in = 8'h5A;
    push(K_WR, 15'h1800, 8'h5A);
    slot_nwr = 1'b0;
    tick(); tick();
    chk("wrreq_before_edge3", wrreq, 1'b0);
    tick();
    chk("wrreq_edge3", wrreq, 1'b1);
    chk("wr_active_edge3", wr_active, 1'b1);
    tick();
    chk("wrreq_one_cycle", wrreq, 1'b0);
    repeat (6) tick();
    slot_nwr = 1'b1;
    tick(); tick();
    chk("wr_active_hold", wr_active, 1'b1);
    tick();
    chk("wr_active_drop", wr_active, 1'b0);
    chk("wr_no_rd", {rd_active, slot_d_oe}, 2'b0);
    repeat (3) tick();

    // Read cycle with OE
    slot_a = 15'h0ABC; q = 8'hC3; ext_mem_ncs = 1'b1;
    push(K_RD, 15'h0ABC, 8'h5A);
    push(K_OE, 15'h0, 8'hC3);
    slot_nrd = 1'b0;
    tick(); tick(); tick();
    chk("rd_active_edge3", rd_active, 1'b1);
    chk("oe_not_yet_e3", slot_d_oe, 1'b0);
    tick();
    chk("oe_not_yet_e4", slot_d_oe, 1'b0);
    tick();
    chk("oe_on_e5", slot_d_oe, 1'b1);
    chk("slot_d_out", slot_d_out, 8'hC3);
    repeat (5) tick();
    slot_nrd = 1'b1;
    tick(); tick();
    chk("oe_hold", slot_d_oe, 1'b1);
    tick();
    chk("rd_oe_drop", {rd_active, slot_d_oe}, 2'b0);
    repeat (3) tick();

    // External memory read: request but no OE
    slot_a = 15'h0123; ext_mem_ncs = 1'b0;
    push(K_RD, 15'h0123, 8'h5A);
    slot_nrd = 1'b0;
    cnt = 0;
    repeat (12) begin tick(); if (slot_d_oe) cnt++; end
    slot_nrd = 1'b1;
    repeat (4) begin tick(); if (slot_d_oe) cnt++; end
    chk("ext_mem_no_oe", cnt, 0);
    ext_mem_ncs = 1'b1;

    // Deselected slot
    slot_nsltsl = 1'b1;
    repeat (4) tick();
    slot_nwr = 1'b0;
    cnt = 0;
    repeat (6) begin tick(); if (wrreq || wr_active || rd_active || rdreq) cnt++; end
    slot_nwr = 1'b1;
    repeat (4) begin tick(); if (wrreq || wr_active || rd_active || rdreq) cnt++; end
    chk("deselect_quiet", cnt, 0);
    slot_nsltsl = 1'b0;
    repeat (4) tick();

    // Held-low write gives one request
    slot_a = 15'h7FFF; slot_d_in = 8'hA5;
    push(K_WR, 15'h7FFF, 8'hA5);
    slot_nwr = 1'b0;
    cnt = 0;
    repeat (100) begin tick(); if (wrreq) cnt++; end
    slot_nwr = 1'b1;
    repeat (4) tick();
    chk("hold_one_wrreq", cnt, 1);

    // Illegal simultaneous strobes
    slot_nrd = 1'b0; slot_nwr = 1'b0;
    cnt = 0;
    repeat (10) begin tick(); if (wrreq || rdreq || wr_active || rd_active) cnt++; end
    slot_nrd = 1'b1; slot_nwr = 1'b1;
    repeat (4) tick();
    chk("illegal_no_req", cnt, 0);

    // Reset in the middle of a read
    slot_a = 15'h2222; q = 8'h3C;
    push(K_RD, 15'h2222, 8'hA5);
    push(K_OE, 15'h0, 8'h3C);
    slot_nrd = 1'b0;
    repeat (6) tick();
    chk("pre_reset_oe", slot_d_oe, 1'b1);
    #2 nreset = 1'b0;
    #1;
    chk("async_reset_clear", {rd_active, slot_d_oe, rdreq}, 3'b0);
    repeat (3) tick();
    @(negedge clk) nreset = 1'b1;
    cnt = 0;
    repeat (12) begin tick(); if (rdreq || rd_active) cnt++; end
    chk("no_req_after_reset", cnt, 0);
    slot_nrd = 1'b1;
    repeat (4) tick();
    slot_a = 15'h4444;
    push(K_RD, 15'h4444, 8'h00);
    push(K_OE, 15'h0, 8'h3C);
    slot_nrd = 1'b0;
    repeat (3) tick();
    chk("rearm_rd_active", rd_active, 1'b1);
    repeat (6) tick();
    slot_nrd = 1'b1;
    repeat (5) tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
